alu_arbiter: RTL and testbench

//  Shares one combinational alu_core instance between NREQ requesters.

---
 rtl/alu_arbiter_pkg.sv | 15 +
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter_rr_pick.sv | 27 ++
 rtl/alu_core.sv | 33 +++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared opcode and arbiter state types for the ALU arbiter slice
package alu_arbiter_pkg;
    typedef enum logic [2:0] {
        ADD = 3'b000,
        AND = 3'b001,
        SUB = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        MUL = 3'b101,
        DIV = 3'b110,
        MIN = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle between requesters and the ALU arbiter
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int N    = 3,
    parameter int NREQ = 2
);
    logic    [NREQ-1:0]        req_valid;
    logic    [NREQ-1:0]        req_ready;
    alu_op_t [NREQ-1:0]        req_op;
    logic    [NREQ-1:0][N-1:0] req_a;
    logic    [NREQ-1:0][N-1:0] req_b;
    logic    [NREQ-1:0]        resp_valid;
    logic    [NREQ-1:0]        resp_ready;
    logic    [2*N-1:0]         resp_data;
    logic                      resp_dz;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_dz
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_dz
    );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (wrapping)
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            j = (j >= NREQ) ? j - NREQ : j;
            if (!any && req[IW'(j)]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing a double-width result; divide by zero yields 0
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  alu_op_t        op,
    output logic [2*N-1:0] y
);
    localparam int W = 2 * N;

    logic [W-1:0] ax, bx;

    assign ax = W'(a);
    assign bx = W'(b);

    always_comb begin
        y = '0;
        unique case (op)
            ADD: y = ax + bx;
            AND: y = ax & bx;
            SUB: y = ax - bx;
            OR:  y = ax | bx;
            XOR: y = ax ^ bx;
            MUL: y = ax * bx;
            DIV: y = (b == '0) ? '0 : ax / bx;
            MIN: y = (a < b) ? ax : bx;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between NREQ requesters,
// one operation in flight, registered operands/result and divide-by-zero flagging.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N    = 3,
    parameter int NREQ = 2,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [N-1:0]     alu_operand1,
    output logic [N-1:0]     alu_operand2,
    output alu_op_t          alu_operation,
    input  logic [2*N-1:0]   alu_result,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);
    localparam int IW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    alu_op_t         op_q, op_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [2*N-1:0]  result_q, result_d;
    logic            dz_q, dz_d;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            div_zero;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign div_zero = (op_q == DIV) && (b_q == '0);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        dz_d       = dz_q;
        op_count_d = op_count_q;
        unique case (state_q)
            IDLE: if (pick_any) begin
                grant_d = pick_idx;
                op_d    = bus.req_op[pick_idx];
                a_d     = bus.req_a[pick_idx];
                b_d     = bus.req_b[pick_idx];
                state_d = EXEC;
            end
            EXEC: begin
                result_d = div_zero ? '1 : alu_result;
                dz_d     = div_zero;
                state_d  = RESP;
            end
            RESP: if (bus.resp_ready[grant_q]) begin
                rr_ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                op_count_d = op_count_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            op_q       <= ADD;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            dz_q       <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            dz_q       <= dz_d;
            op_count_q <= op_count_d;
        end
    end

    // Ready is held off while reset is asserted so nothing is accepted during reset.
    assign bus.req_ready  = (state_q == IDLE && rst_n) ? pick_gnt : '0;
    assign bus.resp_valid = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
    assign bus.resp_data  = (state_q == RESP) ? result_q : '0;
    assign bus.resp_dz    = (state_q == RESP) && dz_q;
    assign alu_operand1   = a_q;
    assign alu_operand2   = b_q;
    assign alu_operation  = op_q;
    assign busy           = (state_q != IDLE);
    assign op_count       = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with the real alu_core (N=3, NREQ=2)
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        bit         idx;
        logic [5:0] data;
        logic       dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  alu_a1, alu_a2;
    alu_op_t     alu_op;
    logic [5:0]  alu_res;
    logic        busy;
    logic [15:0] op_count;

    int   checks = 0;
    int   errors = 0;
    int   rdy_cnt [2] = '{0, 0};
    exp_t sb [$];

    always #5 clk = ~clk;

    alu_arbiter_if #(.N(3), .NREQ(2)) bus ();

    alu_arbiter #(.N(3), .NREQ(2), .CNTW(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_operand1  (alu_a1),
        .alu_operand2  (alu_a2),
        .alu_operation (alu_op),
        .alu_result    (alu_res),
        .busy          (busy),
        .op_count      (op_count)
    );

    alu_core #(.N(3)) u_alu (
        .a  (alu_a1),
        .b  (alu_a2),
        .op (alu_op),
        .y  (alu_res)
    );

    always @(negedge clk) begin
        rdy_cnt[0] <= rdy_cnt[0] + int'(bus.req_ready[0]);
        rdy_cnt[1] <= rdy_cnt[1] + int'(bus.req_ready[1]);
    end

    function automatic logic [6:0] model(alu_op_t op, logic [2:0] a, logic [2:0] b);
        logic [5:0] x, y;
        x = {3'b000, a};
        y = {3'b000, b};
        case (op)
            ADD:     return {1'b0, x + y};
            AND:     return {1'b0, x & y};
            SUB:     return {1'b0, x - y};
            OR:      return {1'b0, x | y};
            XOR:     return {1'b0, x ^ y};
            MUL:     return {1'b0, x * y};
            DIV:     return (b == 3'd0) ? 7'h7F : {1'b0, x / y};
            default: return {1'b0, (a < b) ? x : y};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit i, input alu_op_t op, input logic [2:0] a, input logic [2:0] b);
        logic [6:0] m;
        m = model(op, a, b);
        sb.push_back('{i, m[5:0], m[6]});
    endtask

    task automatic drive(input bit i, input alu_op_t op, input logic [2:0] a, input logic [2:0] b);
        bus.req_valid[i] = 1'b1;
        bus.req_op[i]    = op;
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
        push(i, op, a, b);
    endtask

    task automatic expect_resp(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (bus.resp_valid == 2'b00 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_valid_seen"}, 32'(bus.resp_valid != 2'b00), 1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_resp_valid"}, bus.resp_valid, 2'b01 << e.idx);
            chk({tag, "_resp_data"}, bus.resp_data, e.data);
            chk({tag, "_resp_dz"}, bus.resp_dz, e.dz);
        end
    endtask

    task automatic single_op(input bit i, input alu_op_t op, input logic [2:0] a,
                             input logic [2:0] b, input string tag);
        drive(i, op, a, b);
        #1;
        chk({tag, "_req_ready"}, bus.req_ready, 2'b01 << i);
        tick();
        bus.req_valid[i] = 1'b0;
        expect_resp(tag);
        tick();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r0, r1;
        bus.req_valid  = '0;
        bus.req_op     = '{ADD, ADD};
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_dz", bus.resp_dz, 0);
        chk("rst_alu_a1", alu_a1, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        tick();

        // single ADD with exact EXEC/RESP timing
        bus.resp_ready = 2'b11;
        drive(1'b0, ADD, 3'd3, 3'd2);
        #1;
        chk("t1_req_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid[0] = 1'b0;
        chk("t1_exec_no_resp", bus.resp_valid, 0);
        chk("t1_exec_busy", busy, 1);
        chk("t1_alu_a1", alu_a1, 3);
        chk("t1_alu_a2", alu_a2, 2);
        tick();
        chk("t1_resp_timing", bus.resp_valid, 2'b01);
        expect_resp("t1");
        tick();
        chk("t1_op_count", op_count, 1);
        chk("t1_idle", busy, 0);

        // simultaneous requests from reset pointer
        do_reset();
        bus.resp_ready = 2'b11;
        r0 = rdy_cnt[0];
        r1 = rdy_cnt[1];
        drive(1'b0, AND, 3'd6, 3'd3);
        drive(1'b1, SUB, 3'd5, 3'd7);
        #1;
        chk("t2_first_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid[0] = 1'b0;
        chk("t2_no_ready_exec", bus.req_ready, 0);
        expect_resp("t2a");
        tick();
        chk("t2_second_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid[1] = 1'b0;
        expect_resp("t2b");
        tick();
        chk("t2_ready_cnt0", rdy_cnt[0] - r0, 1);
        chk("t2_ready_cnt1", rdy_cnt[1] - r1, 1);
        bus.req_valid = 2'b11;
        #1;
        chk("t2_ptr_back_0", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;
        #1;

        // divide by zero then a normal divide
        single_op(1'b1, DIV, 3'd6, 3'd0, "t3a");
        single_op(1'b1, DIV, 3'd6, 3'd2, "t3b");

        // held response, resp_ready only on the wrong index
        bus.resp_ready = 2'b10;
        drive(1'b0, MUL, 3'd7, 3'd7);
        #1;
        chk("t4_req_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid[0] = 1'b0;
        drive(1'b1, ADD, 3'd1, 3'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", bus.resp_valid, 2'b01);
            chk("t4_hold_data", bus.resp_data, 49);
            chk("t4_no_grant", bus.req_ready, 0);
            tick();
        end
        bus.resp_ready = 2'b11;
        expect_resp("t4a");
        tick();
        chk("t4_waiter_granted", bus.req_ready, 2'b10);
        tick();
        bus.req_valid[1] = 1'b0;
        expect_resp("t4b");
        tick();

        // async reset during EXEC drops the op
        bus.req_valid[0] = 1'b1;
        bus.req_op[0]    = ADD;
        bus.req_a[0]     = 3'd1;
        bus.req_b[0]     = 3'd2;
        tick();
        bus.req_valid[0] = 1'b0;
        bus.req_valid[1] = 1'b1;
        bus.req_op[1]    = ADD;
        bus.req_a[1]     = 3'd2;
        bus.req_b[1]     = 3'd2;
        chk("t5_busy_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_req_ready", bus.req_ready, 0);
        chk("t5_rst_resp_valid", bus.resp_valid, 0);
        chk("t5_rst_alu_a1", alu_a1, 0);
        chk("t5_rst_alu_a2", alu_a2, 0);
        chk("t5_rst_op_count", op_count, 0);
        tick();
        rst_n = 1'b1;
        push(1'b1, ADD, 3'd2, 3'd2);
        #1;
        chk("t5_req1_granted", bus.req_ready, 2'b10);
        tick();
        bus.req_valid[1] = 1'b0;
        expect_resp("t5");
        tick();
        chk("t5_op_count", op_count, 1);

        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        tick();
        release dut.op_count_q;
        chk("t6_preload", op_count, 16'hFFFF);
        single_op(1'b0, XOR, 3'd5, 3'd3, "t6");
        chk("t6_wrap", op_count, 0);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
